// File: rtl/adder_pkg.sv
// Shared types and elaboration helpers for the pipelined ripple-carry adder.
// Result flags travel as one struct so they are registered together with the sum.
package adder_pkg;

    typedef struct packed {
        logic cout;
        logic ovf;
    } flags_t;

    function automatic int stages_of(input int width, input int seg);
        return width / seg;
    endfunction

    function automatic bit geometry_ok(input int width, input int seg);
        return (seg > 0) && (width >= seg) && (width % seg == 0);
    endfunction

endpackage

// File: rtl/rca_seg.sv
// Combinational SEG-bit ripple segment built from propagate/generate terms.
// c_msb is the carry into the segment's top bit, used for signed overflow.
module rca_seg
    import adder_pkg::*;
#(
    parameter int SEG = 4
) (
    input  logic [SEG-1:0] a_seg,
    input  logic [SEG-1:0] b_seg,
    input  logic           c_in,
    output logic [SEG-1:0] sum,
    output logic           c_out,
    output logic           c_msb
);

    logic [SEG-1:0] p;
    logic [SEG-1:0] g;
    logic [SEG:0]   c;

    assign p = a_seg ^ b_seg;
    assign g = a_seg & b_seg;

    always_comb begin
        c    = '0;
        c[0] = c_in;
        for (int i = 0; i < SEG; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
    end

    assign sum   = p ^ c[SEG-1:0];
    assign c_out = c[SEG];
    assign c_msb = c[SEG-1];

endmodule

// File: rtl/pipe_rca.sv
// Pipelined ripple-carry adder/subtractor: one SEG-bit segment per stage,
// carries registered between stages, single global stall enable.
module pipe_rca
    import adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             cout,
    output logic             ovf
);

    localparam int STAGES = stages_of(WIDTH, SEG);

    if (!geometry_ok(WIDTH, SEG)) begin : g_bad_geometry
        $error("pipe_rca: WIDTH must be a positive multiple of SEG");
    end

    // Handshake: a transfer happens on a rising edge where valid && ready.
    // The whole pipe advances only when the output slot is empty or being
    // taken, so in_ready is combinational from out_valid/out_ready.
    logic en;

    // st_* are the inputs of stage k; *_q are the registers after stage k.
    logic [STAGES-1:0][WIDTH-1:0] st_a, st_b, st_s, nxt_s;
    logic [STAGES-1:0][WIDTH-1:0] a_q, b_q, s_q;
    logic [STAGES-1:0]            st_c, st_v, c_q, v_q;
    logic [STAGES-1:0][SEG-1:0]   seg_sum;
    logic [STAGES-1:0]            seg_co, seg_msb;
    flags_t                       flags_q;

    assign en        = !v_q[STAGES-1] || out_ready;
    assign in_ready  = en;
    assign out_valid = v_q[STAGES-1];
    assign y         = s_q[STAGES-1];
    assign cout      = flags_q.cout;
    assign ovf       = flags_q.ovf;

    // Subtraction is folded in at capture: invert b and the carry-in.
    always_comb begin
        st_a    = '0;
        st_b    = '0;
        st_s    = '0;
        st_c    = '0;
        st_v    = '0;
        st_a[0] = a;
        st_b[0] = b ^ {WIDTH{sub}};
        st_c[0] = cin ^ sub;
        st_v[0] = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            st_a[k] = a_q[k-1];
            st_b[k] = b_q[k-1];
            st_s[k] = s_q[k-1];
            st_c[k] = c_q[k-1];
            st_v[k] = v_q[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_seg
        rca_seg #(.SEG(SEG)) u_seg (
            .a_seg (st_a[k][k*SEG +: SEG]),
            .b_seg (st_b[k][k*SEG +: SEG]),
            .c_in  (st_c[k]),
            .sum   (seg_sum[k]),
            .c_out (seg_co[k]),
            .c_msb (seg_msb[k])
        );
    end

    // Finished low bits ride along; each stage drops its own segment in.
    always_comb begin
        nxt_s = st_s;
        for (int k = 0; k < STAGES; k++) begin
            nxt_s[k][k*SEG +: SEG] = seg_sum[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            c_q     <= '0;
            v_q     <= '0;
            flags_q <= '0;
        end else if (en) begin
            a_q          <= st_a;
            b_q          <= st_b;
            s_q          <= nxt_s;
            c_q          <= seg_co;
            v_q          <= st_v;
            flags_q.cout <= seg_co[STAGES-1];
            flags_q.ovf  <= seg_co[STAGES-1] ^ seg_msb[STAGES-1];
        end
    end

endmodule

// File: tb/tb_pipe_rca.sv
// Bench for pipe_rca: arithmetic reference model, expected-result queue,
// per-cycle compare process, directed latency/stall/bubble/reset scenarios.
module tb_pipe_rca;

    localparam int W      = 16;
    localparam int S      = 4;
    localparam int STAGES = W / S;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // main DUT (16/4)
    logic         in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
    logic [W-1:0] a = '0, b = '0, y;
    logic         cin = 1'b0, sub = 1'b0, cout, ovf;

    pipe_rca #(.WIDTH(W), .SEG(S)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .cout(cout), .ovf(ovf)
    );

    // single-stage DUT (8/8)
    logic       in_valid_w8 = 1'b0, in_ready_w8, out_valid_w8;
    logic [7:0] a_w8 = '0, b_w8 = '0, y_w8;
    logic       cin_w8 = 1'b0, sub_w8 = 1'b0, cout_w8, ovf_w8;

    pipe_rca #(.WIDTH(8), .SEG(8)) dut_w8 (
        .clk(clk), .rst(rst), .in_valid(in_valid_w8), .in_ready(in_ready_w8),
        .a(a_w8), .b(b_w8), .cin(cin_w8), .sub(sub_w8),
        .out_valid(out_valid_w8), .out_ready(1'b1),
        .y(y_w8), .cout(cout_w8), .ovf(ovf_w8)
    );

    // scoreboard
    logic [W+1:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int n_acc  = 0;

    // {cout, ovf, y} from the arithmetic definition of add / subtract
    function automatic logic [W+1:0] model(input int w, input longint av, input longint bv,
                                           input bit cv, input bit sv);
        longint m, half, ci, r, sa, sb, sr;
        bit co, ov;
        logic [W-1:0] yv;
        m    = longint'(1) << w;
        half = m / 2;
        ci   = cv ? 64'sd1 : 64'sd0;
        sa   = (av >= half) ? av - m : av;
        sb   = (bv >= half) ? bv - m : bv;
        if (sv) begin
            r  = av - bv - ci;
            co = (av >= bv + ci);
            sr = sa - sb - ci;
        end else begin
            r  = av + bv + ci;
            co = (r >= m);
            sr = sa + sb + ci;
        end
        ov = (sr < -half) || (sr >= half);
        yv = W'(r & (m - 1));
        return {co, ov, yv};
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // driver: one clock of stimulus, pushes the model result on handshake
    task automatic cycle(input bit r, input bit iv, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input bit cv, input bit sv, input bit ordy);
        @(negedge clk);
        rst       = r;
        in_valid  = iv;
        a         = av;
        b         = bv;
        cin       = cv;
        sub       = sv;
        out_ready = ordy;
        #1;
        if (r) begin
            exp_q.delete();
        end else if (iv && in_ready) begin
            exp_q.push_back(model(W, longint'(av), longint'(bv), cv, sv));
            n_acc++;
        end
    endtask

    task automatic idle(input bit ordy);
        cycle(1'b0, 1'b0, W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), ordy);
    endtask

    task automatic rand_op(input bit ordy);
        cycle(1'b0, 1'b1, W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), ordy);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            idle(1'b1);
            #2;
            n++;
        end
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    // compare process: every cycle with out_valid, outside reset
    always @(negedge clk) begin
        #2;
        if (!rst && out_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out: got y=%0h with nothing outstanding", y);
            end else begin
                if ({cout, ovf, y} !== exp_q[0]) begin
                    errors++;
                    $display("FAIL result: got {cout,ovf,y}=%0h, expected %0h", {cout, ovf, y}, exp_q[0]);
                end
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        logic [W+1:0] e;
        logic [31:0]  ov_bits, exp_bits;
        int           lat, acc0;
        bit           seen, ov_any;

        // pin the model with hand-computed values
        chk("model_add_carry_chain", 64'(model(W, 'h00FF, 'h0001, 0, 0)), 64'h00100);
        chk("model_add_wrap",        64'(model(W, 'hFFFF, 'h0001, 0, 0)), 64'h20000);
        chk("model_sub_borrow",      64'(model(W, 'h0005, 'h0007, 0, 1)), 64'h0FFFE);
        chk("model_sub_ovf",         64'(model(W, 'h8000, 'h0001, 0, 1)), 64'h37FFF);
        chk("model_sub_cin",         64'(model(W, 'h0003, 'h0003, 1, 1)), 64'h0FFFF);
        chk("model_w8_ovf",          64'(model(8, 'h7F, 'h01, 0, 0)),     64'h10080);

        // reset
        cycle(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        idle(1'b1);
        #2;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_y",         64'(y),         64'd0);
        chk("rst_cout",      64'(cout),      64'd0);
        chk("rst_ovf",       64'(ovf),       64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_w8_valid",  64'(out_valid_w8), 64'd0);
        chk("rst_w8_ready",  64'(in_ready_w8),  64'd1);

        // latency of a single add
        cycle(1'b0, 1'b1, 16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b1);
        lat  = 0;
        seen = 0;
        while (!seen && lat < 12) begin
            idle(1'b1);
            #2;
            lat++;
            if (out_valid) begin
                seen = 1;
                chk("lat_y", 64'(y), 64'h0100);
            end
        end
        chk("latency", 64'(lat), 64'(STAGES));
        drain();

        // directed corner operations
        cycle(1'b0, 1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 16'h0005, 16'h0007, 1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 16'h0003, 16'h0003, 1'b1, 1'b1, 1'b1);
        drain();

        // single-stage instance: latency 1
        @(negedge clk);
        in_valid_w8 = 1'b1; a_w8 = 8'h7F; b_w8 = 8'h01; cin_w8 = 1'b0; sub_w8 = 1'b0;
        @(negedge clk);
        in_valid_w8 = 1'b1; a_w8 = 8'hFF; b_w8 = 8'h01;
        #2;
        e = model(8, 'h7F, 'h01, 0, 0);
        chk("w8_valid_1", 64'(out_valid_w8), 64'd1);
        chk("w8_y_1",     64'(y_w8),    64'(e[7:0]));
        chk("w8_ovf_1",   64'(ovf_w8),  64'(e[W]));
        chk("w8_cout_1",  64'(cout_w8), 64'(e[W+1]));
        @(negedge clk);
        in_valid_w8 = 1'b0; a_w8 = 8'h00; b_w8 = 8'h00; cin_w8 = 1'b1; sub_w8 = 1'b1;
        #2;
        e = model(8, 'hFF, 'h01, 0, 0);
        chk("w8_valid_2", 64'(out_valid_w8), 64'd1);
        chk("w8_y_2",     64'(y_w8),    64'(e[7:0]));
        chk("w8_cout_2",  64'(cout_w8), 64'(e[W+1]));
        @(negedge clk);
        #2;
        chk("w8_bubble", 64'(out_valid_w8), 64'd0);

        // back-to-back: 16 ops -> 16 consecutive results
        ov_bits  = '0;
        exp_bits = '0;
        acc0     = n_acc;
        for (int i = 0; i < 24; i++) begin
            if (i < 16) rand_op(1'b1);
            else idle(1'b1);
            #2;
            ov_bits[i] = out_valid;
            if (i >= STAGES && i < STAGES + 16) exp_bits[i] = 1'b1;
        end
        chk("b2b_pattern",  64'(ov_bits), 64'(exp_bits));
        chk("b2b_accepted", 64'(n_acc - acc0), 64'd16);
        drain();

        // bubbles: in_valid 1,0,1
        ov_bits  = '0;
        exp_bits = '0;
        for (int i = 0; i < 10; i++) begin
            if (i == 0 || i == 2) rand_op(1'b1);
            else idle(1'b1);
            #2;
            ov_bits[i] = out_valid;
            if (i == STAGES || i == STAGES + 2) exp_bits[i] = 1'b1;
        end
        chk("bubble_pattern", 64'(ov_bits), 64'(exp_bits));
        drain();

        // stall with a full pipe
        for (int i = 0; i < 8; i++) rand_op(1'b0);
        #2;
        chk("stall_fill",  64'(exp_q.size()), 64'(STAGES));
        chk("stall_valid", 64'(out_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            rand_op(1'b0);
            #2;
            chk("stall_in_ready", 64'(in_ready), 64'd0);
        end
        drain();

        // reset with three operations in flight
        for (int i = 0; i < 3; i++) rand_op(1'b1);
        cycle(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        idle(1'b1);
        #2;
        chk("midrst_valid",    64'(out_valid), 64'd0);
        chk("midrst_y",        64'(y),         64'd0);
        chk("midrst_in_ready", 64'(in_ready),  64'd1);
        ov_any = 0;
        for (int i = 0; i < 8; i++) begin
            idle(1'b1);
            #2;
            ov_any |= out_valid;
        end
        chk("midrst_no_stale", 64'(ov_any), 64'd0);

        // random traffic with random back-pressure
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) != 0) rand_op($urandom_range(0, 3) != 0);
            else idle($urandom_range(0, 3) != 0);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_rca.md
# pipe_rca

Parametrised, pipelined ripple-carry adder/subtractor: WIDTH-bit operands split into SEG-bit segments, one segment resolved per pipeline stage, carry passed stage to stage in registers. Valid/ready handshakes on both sides; full throughput of one operation per cycle with global stall. Used in the lab datapath as the general replacement for the fixed 4-bit registered adder wherever wider operands, subtraction or back-pressure are needed.

## Interface
- WIDTH, 16, operand width in bits; must be a multiple of SEG.
- SEG, 4, bits resolved per pipeline stage; STAGES = WIDTH/SEG (≥1).
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset: synchronous and active-high, sampled on the rising edge of clk.
- in_valid  in  1  operand set a/b/cin/sub is valid.
- in_ready  out  1  block accepts operands this cycle.
- a  in  WIDTH  operand A, unsigned or two's complement.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in (add) / borrow-in (sub).
- sub  in  1  0 = add, 1 = subtract.
- out_valid  out  1  y/cout/ovf hold a valid result.
- out_ready  in  1  consumer takes result this cycle.
- y  out  WIDTH  sum/difference.
- cout  out  1  add: carry-out; sub: 1 = no borrow (a ≥ b + cin unsigned).
- ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- Add: {cout, y} = a + b + cin.
- Sub: y = a − b − cin (mod 2^WIDTH); implemented as a + ~b + !cin, cout = raw carry-out.
- Operand capture: on handshake (in_valid && in_ready) stage 0 registers a, b already conditioned (b XOR {WIDTH{sub}}), effective carry-in (cin XOR sub), and valid.
- Stage k (0..STAGES−1): computes P = a_seg ^ b_seg, G = a_seg & b_seg, ripple through SEG bits from registered carry of stage k−1 (stage 0 uses captured carry); registers SEG sum bits, segment carry-out, and for last stage the carry into MSB.
- Skew: segments above k travel through delay registers until their stage; completed lower sum bits travel through deskew registers so all WIDTH bits of one operation appear together.
- Each stage carries a valid bit; empty slots (bubbles) propagate with valid = 0; data in bubbles is don't-care but must not assert out_valid.
- Global enable en = !out_valid || out_ready; when en = 0 every pipeline register holds.
- in_ready = en (combinational from out_ready and out_valid; documented path).
- Inputs with in_valid = 0 and en = 1 insert a bubble.

## Timing
- Reset (rst = 1 at an edge): all stage valids, out_valid, y, cout, ovf cleared to 0 next cycle; in_ready = 1 after reset since out_valid = 0. Reset mid-operation discards all in-flight results; no out_valid pulse afterwards for them.
- Latency: handshake at edge t → out_valid = 1 with result after edge t + STAGES − 1 (i.e. visible STAGES cycles after operands presented, STAGES = 4 for defaults), if no stall.
- Throughput: one result per cycle while out_ready = 1.
- Stall: out_valid && !out_ready → in_ready = 0, y/cout/ovf/out_valid stable until out_ready = 1; no operation lost or duplicated.
- Simultaneous out handshake and in handshake in same cycle allowed (en = 1).
- STAGES = 1: degenerates to single registered adder, latency 1.
- cin/sub sampled only on input handshake; changing them at other times has no effect.

## Structure
- Shared package adder_pkg: result-flag struct (cout, ovf), localparam helper for STAGES, elaboration check WIDTH % SEG == 0.
- Sub-module rca_seg: combinational SEG-bit P/G ripple segment (inputs a_seg, b_seg, c_in; outputs sum, c_out, c_msb); instantiated STAGES times via generate. All registers in pipe_rca.

## Test plan
- Defaults, add: a=0x00FF, b=0x0001, cin=0 → 4 cycles later y=0x0100, cout=0, ovf=0; a=0xFFFF, b=0x0001 → y=0x0000, cout=1.
- Sub: a=0x0005, b=0x0007, cin=0, sub=1 → y=0xFFFE, cout=0; a=0x8000, b=0x0001 → y=0x7FFF, ovf=1, cout=1.
- Back-to-back 16 random ops with out_ready=1 → 16 consecutive out_valid cycles, results match model in order.
- Stall: hold out_ready=0 for 5 cycles with pipeline full → in_ready=0, y stable, no loss; release → remaining results drain in order.
- Bubbles: in_valid toggling 1,0,1 → out_valid pattern 1,0,1 delayed by latency.
- Reset mid-flight: 3 ops in pipe, rst=1 one cycle → out_valid=0, y=0, no stale results emerge; WIDTH=8/SEG=8 run repeats add case with latency 1.
